// File: rtl/hdr_tm_pkg.sv
// rtl/hdr_tm_pkg.sv - shared widths, reset constants, FSM type and gamma curve for hdr_tonemap
package hdr_tm_pkg;
    localparam int N       = 12;
    localparam int FP      = 8;
    localparam int SCALE_W = 17;
    localparam int NORM_W  = 8;

    localparam logic [SCALE_W-1:0] ACT_S_RST = 17'd16;
    localparam logic [N-1:0]       MIN_RST   = 12'hFFF;

    localparam logic [4:0] GREY_R = 5'd16;
    localparam logic [5:0] GREY_G = 6'd32;
    localparam logic [4:0] GREY_B = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_LOAD
    } tm_state_t;

    // Continuous three-segment curve: slope 2, then 1, then 1/2; 255 maps to 255.
    function automatic logic [NORM_W-1:0] gamma_pwl(input logic [NORM_W-1:0] x);
        logic [NORM_W-1:0] y;
        if (x < 8'd64)
            y = {x[6:0], 1'b0};
        else if (x < 8'd128)
            y = x + 8'd64;
        else
            y = {1'b0, x[7:1]} + 8'd128;
        return y;
    endfunction
endpackage

// File: rtl/hdr_tm_div.sv
// rtl/hdr_tm_div.sv - sequential restoring divider, one quotient bit per cycle
module hdr_tm_div
    import hdr_tm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SCALE_W-1:0] dividend,
    input  logic [N-1:0]       divisor,
    output logic [SCALE_W-1:0] quotient,
    output logic               done
);
    logic [N-1:0] dvs_q;
    logic [N-1:0] rem_q;
    logic [4:0]   cnt_q;
    logic [N:0]   rem_sh;
    logic [N-1:0] rem_sub;
    logic         take;

    // The quotient register doubles as the dividend shift register.
    assign rem_sh  = {rem_q, quotient[SCALE_W-1]};
    assign take    = (rem_sh >= {1'b0, dvs_q});
    assign rem_sub = rem_sh[N-1:0] - dvs_q;
    assign done    = (cnt_q == 5'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            quotient <= dividend;
            rem_q    <= '0;
            dvs_q    <= divisor;
            cnt_q    <= 5'(SCALE_W);
        end else if (abort) begin
            cnt_q <= '0;
        end else if (cnt_q != 5'd0) begin
            rem_q    <= take ? rem_sub : rem_sh[N-1:0];
            quotient <= {quotient[SCALE_W-2:0], take};
            cnt_q    <= cnt_q - 5'd1;
        end
    end
endmodule

// File: rtl/hdr_tonemap.sv
// rtl/hdr_tonemap.sv - global log-domain tone mapper to RGB565; HDR_TM_GAMMA_EN adds a gamma stage
module hdr_tonemap
    import hdr_tm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] lE_red,
    input  logic [N-1:0] lE_green,
    input  logic [N-1:0] lE_blue,
    input  logic         hdr_done,
    input  logic         frame_start,
    output logic [4:0]   red_out,
    output logic [5:0]   green_out,
    output logic [4:0]   blue_out,
    output logic         tm_valid,
    output logic         tm_busy
);
    logic [N-1:0] le [3];
    assign le[0] = lE_red;
    assign le[1] = lE_green;
    assign le[2] = lE_blue;

    logic [N-1:0] run_min, run_max, snap_min;
    logic [N-1:0] px_min, px_max, base_min, base_max;

    always_comb begin
        px_min = le[0];
        px_max = le[0];
        for (int i = 1; i < 3; i++) begin
            if (le[i] < px_min) px_min = le[i];
            if (le[i] > px_max) px_max = le[i];
        end
    end

    // A pixel coincident with frame_start folds into the freshly reloaded stats.
    assign base_min = frame_start ? MIN_RST : run_min;
    assign base_max = frame_start ? '0      : run_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_min  <= MIN_RST;
            run_max  <= '0;
            snap_min <= MIN_RST;
        end else begin
            if (frame_start) snap_min <= run_min;
            if (hdr_done) begin
                run_min <= (px_min < base_min) ? px_min : base_min;
                run_max <= (px_max > base_max) ? px_max : base_max;
            end else begin
                run_min <= base_min;
                run_max <= base_max;
            end
        end
    end

    // An empty frame (max below min) is treated like a zero span.
    logic [N-1:0] span;
    logic         span_flat;
    assign span      = run_max - run_min;
    assign span_flat = (run_max <= run_min);

    tm_state_t          state, state_nx;
    logic               div_start, div_abort, div_done, flat_q;
    logic [SCALE_W-1:0] div_q;
    logic [N-1:0]       act_min;
    logic [SCALE_W-1:0] act_s;
    logic               act_flat;

    hdr_tm_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (17'h10000),
        .divisor  (span),
        .quotient (div_q),
        .done     (div_done)
    );

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (frame_start) begin
            if (span_flat) begin
                state_nx  = ST_LOAD;
                div_abort = 1'b1;
            end else begin
                state_nx  = ST_DIV;
                div_start = 1'b1;
            end
        end else begin
            case (state)
                ST_DIV:  if (div_done) state_nx = ST_LOAD;
                ST_LOAD: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            flat_q   <= 1'b0;
            act_min  <= '0;
            act_s    <= ACT_S_RST;
            act_flat <= 1'b0;
        end else begin
            state <= state_nx;
            if (frame_start) flat_q <= span_flat;
            if (state == ST_LOAD && !frame_start) begin
                act_min  <= snap_min;
                act_s    <= flat_q ? act_s : div_q;
                act_flat <= flat_q;
            end
        end
    end

    assign tm_busy = (state != ST_IDLE);

    // Scale and flat flag travel with each pixel so a LOAD never splits one.
    logic               v1, f1;
    logic [SCALE_W-1:0] s1;
    logic [N-1:0]       d1 [3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            f1 <= 1'b0;
            s1 <= ACT_S_RST;
            for (int i = 0; i < 3; i++) d1[i] <= '0;
        end else begin
            v1 <= hdr_done;
            f1 <= act_flat;
            s1 <= act_s;
            for (int i = 0; i < 3; i++)
                d1[i] <= (le[i] > act_min) ? le[i] - act_min : '0;
        end
    end

    logic [28:0]       prod   [3];
    logic [NORM_W-1:0] norm_c [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i]   = 29'(d1[i]) * 29'(s1);
            norm_c[i] = (prod[i][28:16] != '0) ? 8'hFF : prod[i][15:8];
        end
    end

    logic              v2, f2;
    logic [NORM_W-1:0] n2 [3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            f2 <= 1'b0;
            for (int i = 0; i < 3; i++) n2[i] <= '0;
        end else begin
            v2 <= v1;
            f2 <= f1;
            for (int i = 0; i < 3; i++) n2[i] <= norm_c[i];
        end
    end

    logic              v_fin, f_fin;
    logic [NORM_W-1:0] n_fin [3];

`ifdef HDR_TM_GAMMA_EN
    logic              v3, f3;
    logic [NORM_W-1:0] n3 [3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            f3 <= 1'b0;
            for (int i = 0; i < 3; i++) n3[i] <= '0;
        end else begin
            v3 <= v2;
            f3 <= f2;
            for (int i = 0; i < 3; i++) n3[i] <= gamma_pwl(n2[i]);
        end
    end

    always_comb begin
        v_fin = v3;
        f_fin = f3;
        for (int i = 0; i < 3; i++) n_fin[i] = n3[i];
    end
`else
    always_comb begin
        v_fin = v2;
        f_fin = f2;
        for (int i = 0; i < 3; i++) n_fin[i] = n2[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tm_valid  <= 1'b0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else begin
            tm_valid  <= v_fin;
            red_out   <= f_fin ? GREY_R : n_fin[0][7:3];
            green_out <= f_fin ? GREY_G : n_fin[1][7:2];
            blue_out  <= f_fin ? GREY_B : n_fin[2][7:3];
        end
    end
endmodule

// File: tb/tb_hdr_tonemap.sv
// tb/tb_hdr_tonemap.sv - scoreboard bench for hdr_tonemap with an independent scale/stats model
module tb_hdr_tonemap;
`ifdef HDR_TM_GAMMA_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lE_red = '0, lE_green = '0, lE_blue = '0;
    logic        hdr_done = 1'b0, frame_start = 1'b0;
    logic [4:0]  red_out, blue_out;
    logic [5:0]  green_out;
    logic        tm_valid, tm_busy;

    always #5 clk = ~clk;

    hdr_tonemap dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lE_red      (lE_red),
        .lE_green    (lE_green),
        .lE_blue     (lE_blue),
        .hdr_done    (hdr_done),
        .frame_start (frame_start),
        .red_out     (red_out),
        .green_out   (green_out),
        .blue_out    (blue_out),
        .tm_valid    (tm_valid),
        .tm_busy     (tm_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] rgb;
        int          due;
    } exp_t;
    exp_t sb[$];

    // Model of the active scale, the pending LOAD and the running statistics.
    int m_min = 0, m_s = 16;
    bit m_flat = 0;
    bit pend = 0;
    int p_min, p_s, p_cyc, fs_cyc = -100;
    bit p_flat;
    int r_min = 4095, r_max = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gamma_ref(input int x);
        if (x < 64) return 2 * x;
        if (x < 128) return x + 64;
        return x / 2 + 128;
    endfunction

    function automatic logic [15:0] model_px(input int r, input int g, input int b);
        int v [3];
        int n [3];
        logic [7:0] nb [3];
        v[0] = r; v[1] = g; v[2] = b;
        for (int i = 0; i < 3; i++) begin
            int d;
            d = (v[i] > m_min) ? v[i] - m_min : 0;
            n[i] = (d * m_s) / 256;
            if (n[i] > 255) n[i] = 255;
`ifdef HDR_TM_GAMMA_EN
            n[i] = gamma_ref(n[i]);
`endif
            nb[i] = n[i][7:0];
        end
        if (m_flat) return {5'd16, 6'd32, 5'd16};
        return {nb[0][7:3], nb[1][7:2], nb[2][7:3]};
    endfunction

    task automatic pix(input bit fs, input bit dv, input int r, input int g, input int b);
        bit busy_exp;
        if (pend && cyc >= p_cyc) begin
            m_min = p_min; m_s = p_s; m_flat = p_flat; pend = 0;
        end
        if (dv) sb.push_back('{rgb: model_px(r, g, b), due: cyc + LAT});
        if (fs) begin
            p_min = r_min;
            if (r_max <= r_min) begin
                p_flat = 1; p_s = m_s; p_cyc = cyc + 2;
            end else begin
                p_flat = 0; p_s = 65536 / (r_max - r_min); p_cyc = cyc + 19;
            end
            pend = 1; fs_cyc = cyc;
            r_min = 4095; r_max = 0;
        end
        if (dv) begin
            if (r < r_min) r_min = r;
            if (g < r_min) r_min = g;
            if (b < r_min) r_min = b;
            if (r > r_max) r_max = r;
            if (g > r_max) r_max = g;
            if (b > r_max) r_max = b;
        end
        frame_start = fs;
        hdr_done    = dv;
        lE_red      = 12'(r);
        lE_green    = 12'(g);
        lE_blue     = 12'(b);
        @(posedge clk);
        cyc++;
        #1;
        busy_exp = pend && (cyc > fs_cyc) && (cyc < p_cyc);
        chk("tm_busy", 32'(tm_busy), 32'(busy_exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(0, 0, 0, 0, 0);
    endtask

    task automatic px1(input int v);
        pix(0, 1, v, v, v);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        frame_start = 1'b0;
        hdr_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        m_min = 0; m_s = 16; m_flat = 0; pend = 0;
        r_min = 4095; r_max = 0;
        sb.delete();
        rst_n = 1'b1;
        chk("rst_busy", 32'(tm_busy), 0);
        chk("rst_valid", 32'(tm_valid), 0);
        chk("rst_rgb", {16'd0, red_out, green_out, blue_out}, 0);
    endtask

    always @(negedge clk) begin
        if (tm_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("rgb", {16'd0, red_out, green_out, blue_out}, {16'd0, e.rgb});
            end
        end
    end

    initial begin
        do_reset(3);

        // Reset scale: 0x800 -> norm 128 -> 16/32/16
        px1(12'h800);
        px1(12'h000);
        pix(0, 1, 12'h400, 12'hFFF, 12'h100);
        idle(5);

        // Normal frame 0x100..0x300 -> span 512, S 128
        pix(1, 0, 0, 0, 0);
        px1(12'h100);
        px1(12'h300);
        pix(0, 1, 12'h200, 12'h180, 12'h2FF);
        idle(2);
        pix(1, 0, 0, 0, 0);
        idle(19);
        px1(12'h200);
        px1(12'h300);
        px1(12'h080);
        for (int i = 0; i < 4; i++)
            pix(0, 1, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
        idle(5);

        // Flat frame: only 0x400, then grey regardless of value
        pix(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) px1(12'h400);
        pix(1, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 5; i++)
            pix(0, 1, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
        idle(20);

        // Pixel stream continuing through a division
        pix(1, 0, 0, 0, 0);
        px1(12'h000);
        px1(12'h800);
        pix(1, 1, 12'h300, 12'h600, 12'h100);
        for (int i = 0; i < 24; i++)
            pix(0, 1, $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047));
        idle(5);

        // Coincident start: 0x050 lands in the following snapshot only
        pix(1, 0, 0, 0, 0);
        px1(12'h100);
        px1(12'h300);
        pix(1, 1, 12'h050, 12'h050, 12'h050);
        px1(12'h400);
        idle(19);
        px1(12'h0C0);
        px1(12'h200);
        pix(1, 0, 0, 0, 0);
        idle(19);
        px1(12'h050);
        px1(12'h0C0);
        px1(12'h400);
        idle(5);

        // Reset in the middle of a division
        pix(1, 0, 0, 0, 0);
        idle(6);
        do_reset(1);
        px1(12'h800);
        idle(5);

        // Restart: second frame_start mid-division gives one LOAD
        pix(1, 0, 0, 0, 0);
        px1(12'h200);
        px1(12'h600);
        pix(1, 0, 0, 0, 0);
        px1(12'h100);
        px1(12'h700);
        idle(3);
        pix(1, 0, 0, 0, 0);
        for (int i = 0; i < 26; i++)
            pix(0, 1, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095));
        idle(5);

        // Reset scale, d=0x200 -> norm 32 (red 4, or 8 through the gamma curve)
        do_reset(2);
        px1(12'h200);
        px1(12'h500);
        px1(12'hA00);
        idle(8);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
